// File: rtl/pc_unit_pkg.sv
// Shared constants for the NPC program-counter stage: datapath width,
// boot address and the sequencing FSM state encoding.
package pc_unit_pkg;

    localparam int          RISCV_XLEN = 32;
    localparam logic [31:0] RESET_PC   = 32'h8000_0000;

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_REQ  = 2'd1,
        S_EXEC = 2'd2,
        S_HALT = 2'd3
    } pc_state_t;

endpackage

// File: rtl/pc_unit_if.sv
// Fetch request channel between the PC stage (master) and the IFU (slave).
interface pc_unit_if #(
    parameter int XLEN = 32
) ();

    logic            ifu_req_valid;
    logic            ifu_req_ready;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;

    modport master (
        output ifu_req_valid,
        output pc,
        output pc_plus4,
        input  ifu_req_ready
    );

    modport slave (
        input  ifu_req_valid,
        input  pc,
        input  pc_plus4,
        output ifu_req_ready
    );

endinterface

// File: rtl/pc_unit_pc_next_calc.sv
// Next-PC target selection (JALR > JAL > taken branch > sequential) and the
// word-alignment check on the selected target.
module pc_next_calc #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] rs1,
    input  logic            is_branch,
    input  logic            is_jal,
    input  logic            is_jalr,
    input  logic            br_taken,
    output logic [XLEN-1:0] target,
    output logic            misalign
);

    logic [XLEN-1:0] jalr_sum;

    always_comb begin
        jalr_sum = rs1 + imm;
        target   = pc + XLEN'(4);
        if (is_jalr) begin
            target = {jalr_sum[XLEN-1:1], 1'b0};
        end else if (is_jal || (is_branch && br_taken)) begin
            target = pc + imm;
        end
    end

    // Bit 0 is never checked: JALR clears it and other immediates are even.
    assign misalign = target[1];

endmodule

// File: rtl/pc_unit.sv
// Program-counter stage: issues one fetch per instruction, waits for
// write-back, then commits the next PC or halts.
//
// state  | meaning
// S_BOOT | one idle cycle after reset release
// S_REQ  | fetch request outstanding, pc held stable
// S_EXEC | instruction in flight, waiting for exu_done
// S_HALT | stopped (ebreak or misaligned target), only rst leaves
module pc_unit #(
    parameter int                XLEN     = pc_unit_pkg::RISCV_XLEN,
    parameter logic [XLEN-1:0]   RESET_PC = XLEN'(pc_unit_pkg::RESET_PC)
) (
    input  logic              clk,
    input  logic              rst,
    pc_unit_if.master         ifu,
    input  logic              exu_done,
    input  logic              is_branch,
    input  logic              is_jal,
    input  logic              is_jalr,
    input  logic              BrJp,
    input  logic [XLEN-1:0]   imm,
    input  logic [XLEN-1:0]   rs1,
    input  logic              halt_req,
    output logic              misalign,
    output logic              halted,
    output logic [63:0]       retire_cnt
);

    import pc_unit_pkg::*;

    pc_state_t       state, state_nxt;
    logic [XLEN-1:0] pc_q, pc_nxt;
    logic [XLEN-1:0] target;
    logic            target_misalign;
    logic            retire_inc;
    logic            misalign_nxt;

    pc_next_calc #(.XLEN(XLEN)) u_next_calc (
        .pc        (pc_q),
        .imm       (imm),
        .rs1       (rs1),
        .is_branch (is_branch),
        .is_jal    (is_jal),
        .is_jalr   (is_jalr),
        .br_taken  (BrJp),
        .target    (target),
        .misalign  (target_misalign)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_BOOT;
            pc_q       <= RESET_PC;
            retire_cnt <= 64'd0;
            misalign   <= 1'b0;
        end else begin
            state      <= state_nxt;
            pc_q       <= pc_nxt;
            retire_cnt <= retire_cnt + 64'(retire_inc);
            misalign   <= misalign_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc_q;
        retire_inc   = 1'b0;
        misalign_nxt = 1'b0;
        case (state)
            S_BOOT: state_nxt = S_REQ;
            S_REQ: begin
                if (ifu.ifu_req_ready) state_nxt = S_EXEC;
            end
            S_EXEC: begin
                if (exu_done) begin
                    // ebreak retires but keeps pc, regardless of any jump flags
                    if (halt_req) begin
                        state_nxt  = S_HALT;
                        retire_inc = 1'b1;
                    end else if (target_misalign) begin
                        state_nxt    = S_HALT;
                        misalign_nxt = 1'b1;
                    end else begin
                        state_nxt  = S_REQ;
                        pc_nxt     = target;
                        retire_inc = 1'b1;
                    end
                end
            end
            S_HALT: state_nxt = S_HALT;
            default: state_nxt = S_BOOT;
        endcase
    end

    always_comb begin
        ifu.ifu_req_valid = (state == S_REQ);
        halted            = (state == S_HALT);
        ifu.pc            = pc_q;
        ifu.pc_plus4      = pc_q + XLEN'(4);
    end

    a_no_done_in_req: assert property (@(posedge clk) disable iff (rst)
        !(state == S_REQ && exu_done));

endmodule

// File: tb/tb_pc_unit.sv
// Directed and randomized checks of pc_unit against a behavioural PC model.
module tb_pc_unit;

    localparam int XLEN = 32;
    localparam logic [31:0] BOOT_PC = 32'h8000_0000;

    logic            clk;
    logic            rst;
    logic            exu_done;
    logic            is_branch;
    logic            is_jal;
    logic            is_jalr;
    logic            BrJp;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] rs1;
    logic            halt_req;
    logic            misalign;
    logic            halted;
    logic [63:0]     retire_cnt;

    pc_unit_if #(.XLEN(XLEN)) ifu ();

    pc_unit #(.XLEN(XLEN), .RESET_PC(BOOT_PC)) dut (
        .clk        (clk),
        .rst        (rst),
        .ifu        (ifu.master),
        .exu_done   (exu_done),
        .is_branch  (is_branch),
        .is_jal     (is_jal),
        .is_jalr    (is_jalr),
        .BrJp       (BrJp),
        .imm        (imm),
        .rs1        (rs1),
        .halt_req   (halt_req),
        .misalign   (misalign),
        .halted     (halted),
        .retire_cnt (retire_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] m_pc;
    logic [63:0] m_retire;
    bit          m_halted;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ctrl();
        exu_done  = 1'b0;
        is_branch = 1'b0;
        is_jal    = 1'b0;
        is_jalr   = 1'b0;
        BrJp      = 1'b0;
        halt_req  = 1'b0;
        imm       = '0;
        rs1       = '0;
    endtask

    // Called one time unit after a posedge; leaves the DUT fetching at BOOT_PC.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        m_pc = BOOT_PC; m_retire = 64'd0; m_halted = 1'b0;
        check("rst_pc", 64'(ifu.pc), 64'(BOOT_PC));
        check("rst_retire", retire_cnt, 64'd0);
        check("rst_valid", 64'(ifu.ifu_req_valid), 64'd0);
        check("rst_halted", 64'(halted), 64'd0);
        check("rst_misalign", 64'(misalign), 64'd0);
        tick();
        rst = 1'b0;
        check("boot_valid", 64'(ifu.ifu_req_valid), 64'd0);
        tick();
        check("boot_to_req_valid", 64'(ifu.ifu_req_valid), 64'd1);
    endtask

    task automatic do_instr(input int rdly, input int edly, input bit h, input bit br,
                            input bit jal, input bit jalr, input bit bj,
                            input logic [31:0] im, input logic [31:0] r1);
        logic [31:0] tgt;
        bit          exp_mis;
        for (int i = 0; i < rdly; i++) begin
            ifu.ifu_req_ready = 1'b0;
            check("stall_valid", 64'(ifu.ifu_req_valid), 64'd1);
            check("stall_pc", 64'(ifu.pc), 64'(m_pc));
            tick();
        end
        check("req_valid", 64'(ifu.ifu_req_valid), 64'd1);
        check("req_pc", 64'(ifu.pc), 64'(m_pc));
        check("pc_plus4", 64'(ifu.pc_plus4), 64'(m_pc + 32'd4));
        ifu.ifu_req_ready = 1'b1;
        tick();
        ifu.ifu_req_ready = 1'b0;
        check("exec_valid", 64'(ifu.ifu_req_valid), 64'd0);
        for (int i = 0; i < edly; i++) begin
            // control inputs wiggle without exu_done and must have no effect
            is_jal = 1'($urandom); is_jalr = 1'($urandom); halt_req = 1'($urandom);
            imm = $urandom; rs1 = $urandom;
            tick();
            check("exec_wait_pc", 64'(ifu.pc), 64'(m_pc));
            check("exec_wait_valid", 64'(ifu.ifu_req_valid), 64'd0);
        end
        exu_done = 1'b1; halt_req = h; is_branch = br; is_jal = jal; is_jalr = jalr;
        BrJp = bj; imm = im; rs1 = r1;
        tick();
        clear_ctrl();

        exp_mis = 1'b0;
        if (h) begin
            m_retire++;
            m_halted = 1'b1;
        end else begin
            if (jalr)            tgt = (r1 + im) & ~32'd1;
            else if (jal)        tgt = m_pc + im;
            else if (br && bj)   tgt = m_pc + im;
            else                 tgt = m_pc + 32'd4;
            if (tgt[1]) begin
                exp_mis  = 1'b1;
                m_halted = 1'b1;
            end else begin
                m_pc = tgt;
                m_retire++;
            end
        end
        check("commit_pc", 64'(ifu.pc), 64'(m_pc));
        check("commit_retire", retire_cnt, m_retire);
        check("commit_misalign", 64'(misalign), 64'(exp_mis));
        check("commit_halted", 64'(halted), 64'(m_halted));
        check("commit_valid", 64'(ifu.ifu_req_valid), 64'(!m_halted));
        if (m_halted) begin
            for (int i = 0; i < 3; i++) begin
                ifu.ifu_req_ready = 1'b1;
                tick();
                check("halt_misalign", 64'(misalign), 64'd0);
                check("halt_valid", 64'(ifu.ifu_req_valid), 64'd0);
                check("halt_halted", 64'(halted), 64'd1);
                check("halt_pc", 64'(ifu.pc), 64'(m_pc));
                check("halt_retire", retire_cnt, m_retire);
            end
            ifu.ifu_req_ready = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b0;
        ifu.ifu_req_ready = 1'b0;
        clear_ctrl();
        #1;
        do_reset();

        for (int i = 0; i < 3; i++) do_instr(0, 0, 0, 0, 0, 0, 0, '0, '0);
        check("seq_pc", 64'(ifu.pc), 64'h8000_000C);
        check("seq_retire", retire_cnt, 64'd3);

        do_instr(0, 0, 0, 0, 0, 0, 0, '0, '0);
        do_instr(0, 1, 0, 1, 0, 0, 1, 32'hFFFF_FFF0, '0);
        check("br_taken_pc", 64'(ifu.pc), 64'h8000_0000);
        for (int i = 0; i < 4; i++) do_instr(0, 0, 0, 0, 0, 0, 0, '0, '0);
        do_instr(0, 0, 0, 1, 0, 0, 0, 32'hFFFF_FFF0, '0);
        check("br_not_taken_pc", 64'(ifu.pc), 64'h8000_0014);

        do_instr(5, 0, 0, 0, 0, 0, 0, '0, '0);

        for (int n = 0; n < 60; n++) begin
            do_instr($urandom_range(0, 2), $urandom_range(0, 2), 1'b0,
                     1'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0),
                     1'($urandom), $urandom & 32'hFFFF_FFFC, $urandom & 32'hFFFF_FFFD);
        end

        // asynchronous reset while an instruction is in flight
        ifu.ifu_req_ready = 1'b1;
        tick();
        ifu.ifu_req_ready = 1'b0;
        check("pre_arst_valid", 64'(ifu.ifu_req_valid), 64'd0);
        #3;
        rst = 1'b1;
        #1;
        check("arst_pc", 64'(ifu.pc), 64'(BOOT_PC));
        check("arst_retire", retire_cnt, 64'd0);
        check("arst_valid", 64'(ifu.ifu_req_valid), 64'd0);
        tick();
        rst = 1'b0;
        tick();
        check("arst_boot_req", 64'(ifu.ifu_req_valid), 64'd1);
        m_pc = BOOT_PC; m_retire = 64'd0; m_halted = 1'b0;

        do_instr(0, 0, 0, 0, 0, 1, 0, 32'd2, 32'h8000_0101);
        check("jalr_mis_pc", 64'(ifu.pc), 64'h8000_0000);
        check("jalr_mis_halted", 64'(halted), 64'd1);

        do_reset();
        do_instr(0, 0, 0, 0, 0, 0, 0, '0, '0);
        do_instr(1, 0, 1, 0, 1, 0, 0, 32'h0000_0100, '0);
        check("halt_jal_pc", 64'(ifu.pc), 64'h8000_0004);
        check("halt_jal_retire", retire_cnt, 64'd2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
